// File: rtl/periph_bus_ctrl_pkg.sv
// Shared constants for the peripheral bus controller: I/O offsets, FSM states, UART framing.
package periph_bus_ctrl_pkg;

  localparam logic [11:0] OFF_LED       = 12'h000;
  localparam logic [11:0] OFF_SW        = 12'h004;
  localparam logic [11:0] OFF_UART_DATA = 12'h008;
  localparam logic [11:0] OFF_UART_STAT = 12'h00C;

  // Start bit + 8 data bits + stop bit.
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_RAM_WAIT = 2'd1;
  localparam state_t ST_IO_RESP  = 2'd2;

endpackage

// File: rtl/periph_bus_ctrl_uart_tx.sv
// 8N1 UART transmitter, LSB first; busy covers start bit through end of stop bit.
module uart_tx
  import periph_bus_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(UART_FRAME_BITS);

  logic [CNT_W-1:0] clk_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [8:0]       shreg;

  // Frame sequencer: start bit is driven on acceptance, then data LSB first, then stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      txd     <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!busy) begin
      if (start) begin
        busy    <= 1'b1;
        txd     <= 1'b0;
        shreg   <= {1'b1, data};
        clk_cnt <= '0;
        bit_cnt <= '0;
      end
    end else if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
      clk_cnt <= '0;
      if (bit_cnt == BIT_W'(UART_FRAME_BITS - 1)) begin
        busy <= 1'b0;
        txd  <= 1'b1;
      end else begin
        txd     <= shreg[0];
        shreg   <= {1'b0, shreg[8:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Single-outstanding bus controller routing requests to external RAM or a small I/O window.
module periph_bus_ctrl
  import periph_bus_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LED_W        = 16,
  parameter int unsigned SW_W         = 8,
  parameter int unsigned RAM_LATENCY  = 1,
  parameter logic [31:0] IO_BASE      = 32'h0000_F000,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic              txd
);

  localparam int unsigned       LAT_W     = 3;
  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              accept_c, is_io_c, rsp_valid_nxt;
  logic [11:0]       off_c;
  logic              io_err_c, led_we_c, uart_start_c;
  logic [DATA_W-1:0] io_rdata_c;
  logic [SW_W-1:0]   sw_meta, sw_sync;
  logic              rsp_valid_q, rsp_err_q, rsp_ram_q, rsp_wr_q;
  logic [DATA_W-1:0] io_rdata_q;
  logic              tx_busy;

  // Request acceptance, window decode and the RAM side, which is driven in the accept cycle.
  assign req_ready = (state == ST_IDLE);
  assign accept_c  = req_valid && req_ready;
  assign is_io_c   = (req_addr[ADDR_W-1:12] == IO_BASE_A[ADDR_W-1:12]);
  assign off_c     = req_addr[11:0];
  assign ram_addr  = req_addr;
  assign ram_wdata = req_wdata;
  assign ram_we    = accept_c && !is_io_c && req_write;

  // I/O register decode: read data, error flag and side-effect strobes.
  always_comb begin
    io_err_c     = 1'b0;
    io_rdata_c   = '0;
    led_we_c     = 1'b0;
    uart_start_c = 1'b0;
    if (off_c[1:0] != 2'b00) begin
      io_err_c = 1'b1;
    end else begin
      case (off_c)
        OFF_LED: begin
          if (req_write) led_we_c = accept_c && is_io_c;
          else           io_rdata_c = DATA_W'(led);
        end
        OFF_SW: begin
          if (req_write) io_err_c = 1'b1;
          else           io_rdata_c = DATA_W'(sw_sync);
        end
        OFF_UART_DATA: begin
          if (!req_write || tx_busy) io_err_c = 1'b1;
          else                       uart_start_c = accept_c && is_io_c;
        end
        OFF_UART_STAT: begin
          if (!req_write) io_rdata_c = DATA_W'(tx_busy);
        end
        default: io_err_c = 1'b1;
      endcase
    end
  end

  // Next state and response strobe.
  always_comb begin
    state_nxt     = state;
    rsp_valid_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_nxt     = is_io_c ? ST_IO_RESP : ST_RAM_WAIT;
          rsp_valid_nxt = is_io_c || (RAM_LATENCY == 1);
        end
      end
      ST_RAM_WAIT: begin
        if (lat_cnt == LAT_W'(RAM_LATENCY))     state_nxt     = ST_IDLE;
        if (lat_cnt == LAT_W'(RAM_LATENCY - 1)) rsp_valid_nxt = 1'b1;
      end
      ST_IO_RESP: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State register and RAM latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept_c)                  lat_cnt <= LAT_W'(1);
      else if (state == ST_RAM_WAIT) lat_cnt <= lat_cnt + 1'b1;
    end
  end

  // Response capture; I/O data is latched at acceptance, RAM data is passed through later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ram_q   <= 1'b0;
      rsp_wr_q    <= 1'b0;
      io_rdata_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_nxt;
      if (accept_c) begin
        rsp_ram_q  <= !is_io_c;
        rsp_wr_q   <= req_write;
        rsp_err_q  <= is_io_c && io_err_c;
        io_rdata_q <= (is_io_c && !io_err_c) ? io_rdata_c : '0;
      end
    end
  end

  // Response outputs are forced to zero outside the response pulse.
  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid_q) begin
      if (!rsp_ram_q)     rsp_rdata = io_rdata_q;
      else if (!rsp_wr_q) rsp_rdata = ram_rdata;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q && rsp_err_q;

  // LED register and two-flop switch synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led     <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (led_we_c) led <= req_wdata[LED_W-1:0];
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .reset(reset),
    .start(uart_start_c),
    .data (req_wdata[7:0]),
    .busy (tx_busy),
    .txd  (txd)
  );

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Randomised self-checking bench for periph_bus_ctrl against a transaction-level model.
module tb_periph_bus_ctrl;

  localparam int          RAM_LAT = 2;
  localparam int          CPB     = 4;
  localparam logic [31:0] IOB     = 32'h0000_F000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        txd;

  periph_bus_ctrl #(
    .DATA_W(32), .ADDR_W(32), .LED_W(16), .SW_W(8),
    .RAM_LATENCY(RAM_LAT), .IO_BASE(IOB), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw(sw), .led(led), .txd(txd)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference state
  logic [15:0] led_m;
  logic [7:0]  sw_m;
  int          fs = -1;
  logic [7:0]  fbyte;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] env_mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC3A5_0F00;
  endfunction

  function automatic bit in_io(input logic [31:0] a);
    return (a >= IOB) && (a < IOB + 32'h1000);
  endfunction

  function automatic bit uart_busy(input int c);
    return (fs >= 0) && (c > fs) && (c <= fs + 10 * CPB);
  endfunction

  function automatic logic exp_txd(input int c);
    int idx;
    if (!uart_busy(c)) return 1'b1;
    idx = (c - fs - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return fbyte[idx-1];
  endfunction

  // RAM environment with RAM_LAT cycles of read latency.
  logic [31:0] pipe_addr;
  always @(posedge clk) begin
    if (ram_we) env_mem[ram_addr] = ram_wdata;
    ram_rdata <= env_mem.exists(pipe_addr) ? env_mem[pipe_addr] : dflt(pipe_addr);
    pipe_addr <= ram_addr;
  end

  // Per-cycle line checks.
  always @(negedge clk) begin
    #2;
    check_eq("txd", 32'(txd), 32'(exp_txd(cyc)));
    check_eq("ram_we", 32'(ram_we), 32'(req_valid && req_write && !in_io(req_addr)));
  end

  // Model of one access: expected response, plus model side effects.
  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input int n, output logic [31:0] ed, output logic ee);
    logic [11:0] off;
    ed = 32'h0; ee = 1'b0;
    off = a[11:0] - IOB[11:0];
    if (!in_io(a)) begin
      if (wr) ref_mem[a] = d;
      else    ed = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    end else if (off[1:0] != 2'b00 || off > 12'h00C) begin
      ee = 1'b1;
    end else if (off == 12'h000) begin
      if (wr) led_m = d[15:0];
      else    ed = {16'h0, led_m};
    end else if (off == 12'h004) begin
      if (wr) ee = 1'b1;
      else    ed = {24'h0, sw_m};
    end else if (off == 12'h008) begin
      if (!wr || uart_busy(n)) ee = 1'b1;
      else begin fs = n; fbyte = d[7:0]; end
    end else begin
      if (!wr) ed = {31'h0, uart_busy(n)};
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ed;
    logic        ee;
    int          lat;
    @(negedge clk);
    model_access(wr, a, d, cyc, ed, ee);
    lat = in_io(a) ? 1 : RAM_LAT;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    check_eq("ready_idle", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_write = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check_eq("ready_busy", 32'(req_ready), 32'h0);
      if (k == 1) check_eq("led", 32'(led), 32'(led_m));
      if (k < lat) begin
        check_eq("rsp_early", 32'(rsp_valid), 32'h0);
        check_eq("rdata_idle", rsp_rdata, 32'h0);
      end else begin
        check_eq("rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("rsp_rdata", rsp_rdata, ed);
        check_eq("rsp_err", 32'(rsp_err), 32'(ee));
      end
    end
    @(negedge clk);
    check_eq("rsp_pulse", 32'(rsp_valid), 32'h0);
    check_eq("err_idle", 32'(rsp_err), 32'h0);
    check_eq("ready_back", 32'(req_ready), 32'h1);
  endtask

  task automatic set_sw(input logic [7:0] v);
    @(negedge clk);
    sw = v; sw_m = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic assert_reset_now();
    reset = 1'b1; fs = -1; led_m = 16'h0;
    #1;
    check_eq("rst_txd", 32'(txd), 32'h1);
    check_eq("rst_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_led", 32'(led), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_hold_valid", 32'(rsp_valid), 32'h0);
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("post_rst_ready", 32'(req_ready), 32'h1);
      check_eq("post_rst_valid", 32'(rsp_valid), 32'h0);
    end
  endtask

  initial begin
    int r;
    logic [31:0] a;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    sw = 8'h0; sw_m = 8'h0; led_m = 16'h0; pipe_addr = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("reset_ready", 32'(req_ready), 32'h1);
    check_eq("reset_valid", 32'(rsp_valid), 32'h0);
    check_eq("reset_err", 32'(rsp_err), 32'h0);
    check_eq("reset_rdata", rsp_rdata, 32'h0);
    check_eq("reset_led", 32'(led), 32'h0);
    check_eq("reset_txd", 32'(txd), 32'h1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed scenarios
    env_mem[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;
    do_req(1'b0, 32'h10, 32'h0);
    do_req(1'b1, IOB, 32'h0001_A5A5);
    do_req(1'b0, IOB, 32'h0);
    set_sw(8'h3C);
    do_req(1'b0, IOB + 32'h4, 32'h0);
    do_req(1'b1, IOB + 32'h4, 32'hFFFF_FFFF);
    do_req(1'b1, IOB + 32'h8, 32'h55);
    do_req(1'b0, IOB + 32'hC, 32'h0);
    do_req(1'b1, IOB + 32'h8, 32'hAA);
    repeat (45) @(negedge clk);
    do_req(1'b0, IOB + 32'hC, 32'h0);
    do_req(1'b0, IOB + 32'h10, 32'h0);
    do_req(1'b0, IOB + 32'h2, 32'h0);
    do_req(1'b0, IOB + 32'h8, 32'h0);
    do_req(1'b1, 32'h0002_0004, 32'h1234_5678);
    do_req(1'b0, 32'h0002_0004, 32'h0);

    // Random traffic
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin
          a = 32'($urandom_range(0, 15)) << 2;
          if ($urandom_range(0, 1) == 1) a = a + 32'h0002_0000;
          do_req(1'($urandom_range(0, 1)), a, $urandom);
        end
        3: do_req(1'($urandom_range(0, 1)), IOB, $urandom);
        4: begin
          if ($urandom_range(0, 1) == 1) set_sw(8'($urandom));
          do_req(1'b0, IOB + 32'h4, 32'h0);
        end
        5: do_req(1'b1, IOB + 32'h8, $urandom);
        6: do_req(1'b0, IOB + 32'hC, 32'h0);
        7: do_req(1'($urandom_range(0, 1)), IOB + 32'($urandom_range(0, 4095)), $urandom);
        8: repeat ($urandom_range(1, 20)) @(negedge clk);
        default: begin
          a = $urandom;
          if (in_io(a)) a = a ^ 32'h0001_0000;
          do_req(1'($urandom_range(0, 1)), a, $urandom);
        end
      endcase
    end

    // Reset during RAM_WAIT
    repeat (45) @(negedge clk);
    do_req(1'b1, IOB, 32'h0000_BEEF);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
    @(posedge clk);
    #1 req_valid = 1'b0;
    assert_reset_now();

    // Reset mid-frame
    do_req(1'b1, IOB + 32'h8, 32'h0F);
    do_req(1'b1, IOB, 32'h0000_0777);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    assert_reset_now();
    do_req(1'b0, IOB + 32'hC, 32'h0);
    do_req(1'b0, IOB, 32'h0);
    do_req(1'b1, IOB + 32'h8, 32'hC3);
    repeat (45) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
